// File: rtl/leds_pkg.sv
// Shared definitions for the LED pattern generator.
//   mode_e    : 3-bit MODE encodings (values 5..7 are unnamed and treated as OFF)
//   calc_div  : clock divider ratio from input clock and step rate
package leds_pkg;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_BLINK  = 3'd1,
    MODE_SHIFT  = 3'd2,
    MODE_BOUNCE = 3'd3,
    MODE_COUNT  = 3'd4
  } mode_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned step_hz);
    return clk_hz / step_hz;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler.
//   CLK  : system clock
//   RST  : asynchronous reset, active-high (count -> 0)
//   EN   : 1 = count advances, 0 = count holds
//   CLR  : synchronous clear, overrides EN
//   TICK : combinational, high while count == DIV-1 and EN=1
module led_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (EN) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign TICK = EN && (cnt_q == LAST);

endmodule

// File: rtl/leds_pattern_gen.sv
// Parametrised LED pattern driver with PWM dimming.
//   CLK       : system clock
//   RST       : asynchronous reset, active-high
//   EN        : 1 = pattern advances, 0 = prescaler and pattern frozen
//   MODE      : 0 OFF, 1 BLINK, 2 SHIFT, 3 BOUNCE, 4 COUNT, 5..7 OFF
//   BRIGHT    : PWM duty level, 0 = dark, all-ones = fully on
//   LEDS      : registered LED drive, bit 0 = LED0
//   STEP_TICK : one-cycle pulse on every pattern step
module leds_pattern_gen
  import leds_pkg::*;
#(
  parameter int unsigned N_LEDS   = 8,
  parameter int unsigned CLK_HZ   = 12_000_000,
  parameter int unsigned STEP_HZ  = 4,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [2:0]          MODE,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic [N_LEDS-1:0]   LEDS,
  output logic                STEP_TICK
);

  localparam int unsigned DIV = calc_div(CLK_HZ, STEP_HZ);

  logic [2:0]          mode_q, mode_d;
  logic [N_LEDS-1:0]   pattern_q, pattern_d;
  logic                dir_up_q, dir_up_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [N_LEDS-1:0]   leds_q, leds_d;
  logic                step_tick_q, step_tick_d;

  logic mode_chg;
  logic tick;
  logic step;
  logic pwm_on;

  function automatic logic [N_LEDS-1:0] init_pattern(input logic [2:0] m);
    logic [N_LEDS-1:0] p;
    p = '0;
    if (m == MODE_SHIFT || m == MODE_BOUNCE) begin
      p[0] = 1'b1;
    end
    return p;
  endfunction

  assign mode_chg = (MODE != mode_q);

  // A mode change clears the prescaler in the same cycle, so a coincident
  // tick never reaches the pattern or STEP_TICK.
  led_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .CLR  (mode_chg),
    .TICK (tick)
  );

  assign step = tick && !mode_chg;

  always_comb begin
    mode_d      = mode_q;
    pattern_d   = pattern_q;
    dir_up_d    = dir_up_q;
    step_tick_d = step;
    if (mode_chg) begin
      mode_d    = MODE;
      pattern_d = init_pattern(MODE);
      dir_up_d  = 1'b1;
    end else if (step) begin
      case (mode_q)
        MODE_BLINK: begin
          pattern_d = '0;
          pattern_d[N_LEDS-1] = ~pattern_q[N_LEDS-1];
        end
        MODE_SHIFT: begin
          pattern_d = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
        end
        MODE_BOUNCE: begin
          // Reverse when the lit bit sits at the end it is heading toward,
          // moving away in the same step so the end position is shown once.
          if (dir_up_q) begin
            if (pattern_q[N_LEDS-1]) begin
              dir_up_d  = 1'b0;
              pattern_d = pattern_q >> 1;
            end else begin
              pattern_d = pattern_q << 1;
            end
          end else begin
            if (pattern_q[0]) begin
              dir_up_d  = 1'b1;
              pattern_d = pattern_q << 1;
            end else begin
              pattern_d = pattern_q >> 1;
            end
          end
        end
        MODE_COUNT: begin
          pattern_d = pattern_q + 1'b1;
        end
        default: begin
          pattern_d = '0;
        end
      endcase
    end
  end

  assign pwm_cnt_d = pwm_cnt_q + 1'b1;
  assign pwm_on    = (pwm_cnt_q < BRIGHT) || (&BRIGHT);
  assign leds_d    = pattern_q & {N_LEDS{pwm_on}};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q      <= MODE_OFF;
      pattern_q   <= '0;
      dir_up_q    <= 1'b1;
      pwm_cnt_q   <= '0;
      leds_q      <= '0;
      step_tick_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      pattern_q   <= pattern_d;
      dir_up_q    <= dir_up_d;
      pwm_cnt_q   <= pwm_cnt_d;
      leds_q      <= leds_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign LEDS      = leds_q;
  assign STEP_TICK = step_tick_q;

endmodule
